// File: rtl/sign_bit_cost_cg.sv
// sign_bit_cost_cg: per-CG sign bypass-bin cost with sign-data-hiding (start edge -> CG_SIZE coef beats -> done pulse with num_signs/sign_hidden/sign_bit_cost)
module sign_bit_cost_cg #(
  parameter int IEP_RATE   = 32768,
  parameter int COEF_W     = 16,
  parameter int CG_SIZE    = 16,
  parameter int COST_W     = 32,
  parameter int SBH_THRESH = 4,
  localparam int NZ_W      = $clog2(CG_SIZE + 1),
  localparam int POS_W     = $clog2(CG_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sbh_en,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_level,
  output logic [COST_W-1:0] sign_bit_cost,
  output logic [NZ_W-1:0]   num_signs,
  output logic              sign_hidden,
  output logic              done,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, CALC = 2'd2, DONE = 2'd3;
  if (64'(CG_SIZE) * 64'(IEP_RATE) >= (64'd1 << COST_W)) begin : g_bad_cost_w
    $error("sign_bit_cost_cg: COST_W too small for CG_SIZE*IEP_RATE");
  end
  logic [1:0]       state;
  logic             start_d, start_q, seen, sbh_lat, hid;
  logic [POS_W-1:0] pos, first_pos, last_pos;
  logic [NZ_W-1:0]  nz_cnt, n_code;
  logic [COST_W-1:0] cost;
  always_comb begin
    start_q = start & ~start_d;
    hid     = sbh_lat && nz_cnt != '0 && 32'(last_pos - first_pos) >= SBH_THRESH;
    n_code  = nz_cnt - NZ_W'(hid);
    cost    = COST_W'(n_code) * COST_W'(IEP_RATE);
  end
  assign coef_ready = state == ACCUM;
  assign done       = state == DONE;
  assign busy       = state == ACCUM || state == CALC;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_d       <= 1'b0;
      pos           <= '0;
      nz_cnt        <= '0;
      first_pos     <= '0;
      last_pos      <= '0;
      seen          <= 1'b0;
      sbh_lat       <= 1'b0;
      sign_bit_cost <= '0;
      num_signs     <= '0;
      sign_hidden   <= 1'b0;
    end else begin
      start_d <= start;
      if ((state == IDLE || state == DONE) && start_q) begin
        state   <= ACCUM;
        pos     <= '0;
        nz_cnt  <= '0;
        seen    <= 1'b0;
        sbh_lat <= sbh_en;
      end else begin
        case (state)
          ACCUM: if (coef_valid) begin
            if (coef_level != '0) begin
              nz_cnt   <= nz_cnt + 1'b1;
              last_pos <= pos;
              if (!seen) begin
                first_pos <= pos;
                seen      <= 1'b1;
              end
            end
            pos <= pos + 1'b1;
            if (pos == POS_W'(CG_SIZE - 1)) state <= CALC;
          end
          CALC: begin
            sign_hidden   <= hid;
            num_signs     <= n_code;
            sign_bit_cost <= cost;
            state         <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
